// File: rtl/hazard_scoreboard.sv
// Destination-tag scoreboard for the ID/EX, EX/MEM and MEM/WB stages; raises a
// one-cycle load-use stall. Optional macro HAZARD_BR_STALL_EN adds ID-stage branch hazards.
module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rw,
  input  logic             id_memread,
  input  logic             id_is_br,
  input  logic             flush,
  output logic             stall,
  output logic [REG_W-1:0] id_ex_rd,
  output logic             id_ex_rw,
  output logic [REG_W-1:0] ex_mem_rd,
  output logic             ex_mem_rw,
  output logic [REG_W-1:0] mem_wb_rd,
  output logic             mem_wb_rw,
  output logic [CNT_W-1:0] stall_count
);

  logic [REG_W-1:0] r_id_ex_rd, r_ex_mem_rd, r_mem_wb_rd;
  logic             r_id_ex_rw, r_ex_mem_rw, r_mem_wb_rw;
  logic             r_id_ex_mr;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rs_hit, w_rt_hit, w_load_use, w_br_haz, w_stall, w_bubble;

  assign w_rs_hit   = id_uses_rs & (id_rs == r_id_ex_rd);
  assign w_rt_hit   = id_uses_rt & (id_rt == r_id_ex_rd);
  assign w_load_use = id_valid & r_id_ex_mr & r_id_ex_rw & (r_id_ex_rd != '0)
                    & (w_rs_hit | w_rt_hit);

`ifdef HAZARD_BR_STALL_EN
  logic r_ex_mem_mr;

  // Branch operands are consumed in ID, so any ID/EX writer or an EX/MEM load blocks it
  assign w_br_haz = id_valid & id_is_br
                  & (((id_rs == r_id_ex_rd) & r_id_ex_rw & (r_id_ex_rd != '0))
                   | ((id_rs == r_ex_mem_rd) & r_ex_mem_rw & r_ex_mem_mr));

  always_ff @(posedge clk) begin
    if (!rst_n) r_ex_mem_mr <= 1'b0;
    else        r_ex_mem_mr <= r_id_ex_mr;
  end
`else
  logic w_unused_br;
  assign w_unused_br = id_is_br;
  assign w_br_haz    = 1'b0;
`endif

  assign w_stall  = (w_load_use | w_br_haz) & ~flush;
  assign w_bubble = ~id_valid | flush | w_stall;

  // ---- stage boundary: ID -> ID/EX -> EX/MEM -> MEM/WB ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id_ex_rd  <= '0;
      r_id_ex_rw  <= 1'b0;
      r_id_ex_mr  <= 1'b0;
      r_ex_mem_rd <= '0;
      r_ex_mem_rw <= 1'b0;
      r_mem_wb_rd <= '0;
      r_mem_wb_rw <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_mem_wb_rd <= r_ex_mem_rd;
      r_mem_wb_rw <= r_ex_mem_rw;
      r_ex_mem_rd <= r_id_ex_rd;
      r_ex_mem_rw <= r_id_ex_rw;
      r_id_ex_rd  <= w_bubble ? '0 : id_rd;
      r_id_ex_rw  <= ~w_bubble & id_rw & (id_rd != '0);
      r_id_ex_mr  <= ~w_bubble & id_memread;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall       = w_stall;
  assign id_ex_rd    = r_id_ex_rd;
  assign id_ex_rw    = r_id_ex_rw;
  assign ex_mem_rd   = r_ex_mem_rd;
  assign ex_mem_rw   = r_ex_mem_rw;
  assign mem_wb_rd   = r_mem_wb_rd;
  assign mem_wb_rw   = r_mem_wb_rw;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs, id_uses_rt, id_rw, id_memread, id_is_br, flush;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic        stall;
  logic [3:0]  id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic        id_ex_rw, ex_mem_rw, mem_wb_rw;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic last_stall;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_rw(id_rw),
    .id_memread(id_memread), .id_is_br(id_is_br), .flush(flush), .stall(stall),
    .id_ex_rd(id_ex_rd), .id_ex_rw(id_ex_rw), .ex_mem_rd(ex_mem_rd), .ex_mem_rw(ex_mem_rw),
    .mem_wb_rd(mem_wb_rd), .mem_wb_rw(mem_wb_rw), .stall_count(stall_count)
  );

  // Reference model: in-flight instruction list, youngest at the front
  typedef struct {
    logic [3:0] rd;
    logic       rw;
    logic       mr;
  } ent_t;
  ent_t inflight[$];
  int   m_cnt;

  function automatic ent_t empty_ent();
    ent_t e;
    e.rd = 4'd0; e.rw = 1'b0; e.mr = 1'b0;
    return e;
  endfunction

  function automatic logic model_stall();
    logic h;
    ent_t a, b;
    a = inflight[0];
    b = inflight[1];
    h = id_valid && a.mr && a.rw && (a.rd != 0) &&
        ((id_uses_rs && id_rs == a.rd) || (id_uses_rt && id_rt == a.rd));
`ifdef HAZARD_BR_STALL_EN
    if (id_valid && id_is_br &&
        ((id_rs == a.rd && a.rw && a.rd != 0) || (id_rs == b.rd && b.rw && b.mr)))
      h = 1'b1;
`endif
    return h && !flush;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) inflight.push_back(empty_ent());
    m_cnt = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      inflight.delete();
      for (int i = 0; i < 3; i++) inflight.push_back(empty_ent());
      m_cnt  = 0;
      chk_en = 1'b1;
    end else begin
      ent_t e;
      logic s;
      s = model_stall();
      e = empty_ent();
      if (id_valid && !flush && !s) begin
        e.rd = id_rd;
        e.rw = id_rw && (id_rd != 0);
        e.mr = id_memread;
      end
      if (s && m_cnt != 65535) m_cnt = m_cnt + 1;
      inflight.push_front(e);
      void'(inflight.pop_back());
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_stall",     int'(stall),       int'(model_stall()));
      cmp("m_id_ex_rd",  int'(id_ex_rd),    int'(inflight[0].rd));
      cmp("m_id_ex_rw",  int'(id_ex_rw),    int'(inflight[0].rw));
      cmp("m_ex_mem_rd", int'(ex_mem_rd),   int'(inflight[1].rd));
      cmp("m_ex_mem_rw", int'(ex_mem_rw),   int'(inflight[1].rw));
      cmp("m_mem_wb_rd", int'(mem_wb_rd),   int'(inflight[2].rd));
      cmp("m_mem_wb_rw", int'(mem_wb_rw),   int'(inflight[2].rw));
      cmp("m_count",     int'(stall_count), m_cnt);
    end
  end

  // One cycle of ID inputs; returns 1 time unit after the capturing edge
  task automatic drive(input logic v, input logic [3:0] rs, input logic urs,
                       input logic [3:0] rt, input logic urt, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic br, input logic fl);
    id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_rd = rd; id_rw = rw; id_memread = mr; id_is_br = br; flush = fl;
    #2;
    last_stall = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rd = 0; id_rw = 0; id_memread = 0; id_is_br = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp("rst_id_ex_rd", int'(id_ex_rd), 0);
    cmp("rst_count", int'(stall_count), 0);
    cmp("rst_stall", int'(stall), 0);

    // Plain ALU write of r5 walks down the three stages
    drive(1, 4'd1, 1, 4'd2, 1, 4'd5, 1, 0, 0, 0);
    cmp("alu_stall", int'(last_stall), 0);
    cmp("alu_id_ex_rd", int'(id_ex_rd), 5);
    cmp("alu_id_ex_rw", int'(id_ex_rw), 1);
    nop();
    cmp("alu_ex_mem_rd", int'(ex_mem_rd), 5);
    nop();
    cmp("alu_mem_wb_rd", int'(mem_wb_rd), 5);
    cmp("alu_mem_wb_rw", int'(mem_wb_rw), 1);

    // Load r3 then reader of r3 on rt: one stall, then reader proceeds
    drive(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0, 0);
    drive(1, 4'd1, 1, 4'd3, 1, 4'd4, 1, 0, 0, 0);
    cmp("lu_stall", int'(last_stall), 1);
    cmp("lu_bubble_rw", int'(id_ex_rw), 0);
    cmp("lu_ex_mem_rd", int'(ex_mem_rd), 3);
    cmp("lu_ex_mem_rw", int'(ex_mem_rw), 1);
    cmp("lu_count", int'(stall_count), 1);
    drive(1, 4'd1, 1, 4'd3, 1, 4'd4, 1, 0, 0, 0);
    cmp("lu_release", int'(last_stall), 0);
    cmp("lu_reader_rd", int'(id_ex_rd), 4);

    // Load into r0 is never tracked
    drive(1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 1, 0, 0);
    cmp("r0_id_ex_rw", int'(id_ex_rw), 0);
    drive(1, 4'd0, 1, 4'd0, 1, 4'd0, 1, 0, 0, 0);
    cmp("r0_stall", int'(last_stall), 0);
    cmp("r0_ex_mem_rw", int'(ex_mem_rw), 0);
    cmp("r0_id_ex_rw2", int'(id_ex_rw), 0);

    // Invalid ID slot raises no hazard
    drive(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 1, 0, 0);
    drive(0, 4'd2, 1, 4'd2, 1, 4'd6, 1, 0, 0, 0);
    cmp("inv_stall", int'(last_stall), 0);
    cmp("inv_id_ex_rw", int'(id_ex_rw), 0);

    // Hazard plus flush: flush wins
    drive(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0, 0);
    drive(1, 4'd0, 0, 4'd3, 1, 4'd8, 1, 0, 0, 1);
    cmp("fl_stall", int'(last_stall), 0);
    cmp("fl_bubble_rw", int'(id_ex_rw), 0);
    cmp("fl_bubble_rd", int'(id_ex_rd), 0);
    cmp("fl_count", int'(stall_count), 1);

    // Reset during an active hazard discards everything
    drive(1, 4'd0, 0, 4'd0, 0, 4'd6, 1, 1, 0, 0);
    rst_n = 1'b0;
    drive(1, 4'd6, 1, 4'd0, 0, 4'd9, 1, 0, 0, 0);
    cmp("rh_stall_before", int'(last_stall), 1);
    rst_n = 1'b1;
    cmp("rh_id_ex_rd", int'(id_ex_rd), 0);
    cmp("rh_ex_mem_rd", int'(ex_mem_rd), 0);
    cmp("rh_ex_mem_rw", int'(ex_mem_rw), 0);
    cmp("rh_count", int'(stall_count), 0);
    drive(1, 4'd6, 1, 4'd0, 0, 4'd9, 1, 0, 0, 0);
    cmp("rh_stall_after", int'(last_stall), 0);

    // Load r7 followed by a register-indirect branch on r7
    nop();
    nop();
    drive(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 1, 0, 0);
    drive(1, 4'd7, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0);
`ifdef HAZARD_BR_STALL_EN
    cmp("br_stall1", int'(last_stall), 1);
    drive(1, 4'd7, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0);
    cmp("br_stall2", int'(last_stall), 1);
    drive(1, 4'd7, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0);
    cmp("br_release", int'(last_stall), 0);
    cmp("br_count", int'(stall_count), 2);
`else
    cmp("br_nostall", int'(last_stall), 0);
    drive(1, 4'd7, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0);
    cmp("br_nostall2", int'(last_stall), 0);
    cmp("br_count", int'(stall_count), 0);
`endif
    nop();
    nop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
